apb_master: RTL and testbench

- Single-outstanding APB initiator that turns a simple command/response interface into APB SETUP/ACCESS transfers.
- Sits between a local controller (CPU bridge, test sequencer or UART command parser) and the team's APB register-file responders, such as the LED register bank at 16'h0100.
- Provides a timeout so a non-responding slave cannot hang the bus.

---
 rtl/apb_pkg.sv | 17 +
 rtl/apb_master.sv | 148 ++++++++++++++
 tb/tb_apb_master.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/apb_pkg.sv
// Shared APB definitions: FSM state encoding, default bus widths and the
// read value returned by responders for addresses they do not decode.
package apb_pkg;

  localparam int APB_ADDR_W = 16;
  localparam int APB_DATA_W = 32;

  // Returned by every responder (and bench model) for an unmapped address.
  localparam logic [APB_DATA_W-1:0] APB_DEFAULT_RDATA = 32'h1234_5678;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

endpackage

// File: rtl/apb_master.sv
// Single-outstanding APB initiator. A command accepted in IDLE becomes one
// SETUP cycle followed by ACCESS cycles until pready (or the timeout), then
// a one-cycle response pulse is issued in the following IDLE cycle.
//
// Handshake: the command is transferred on a rising edge where
// cmd_valid && cmd_ready; cmd_ready is high only while the FSM is in IDLE.
// rsp_valid is a single-cycle pulse with no backpressure; rsp_rdata and
// rsp_err hold until the next response.
module apb_master
  import apb_pkg::*;
#(
  parameter int ADDR_W  = APB_ADDR_W,
  parameter int DATA_W  = APB_DATA_W,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rstn,
  // command side
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  // response side
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  // APB side
  output logic [ADDR_W-1:0] paddr,
  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  output logic [DATA_W-1:0] pwdata,
  input  logic [DATA_W-1:0] prdata,
  input  logic              pready,
  input  logic              pslverr,
  // debug view of the FSM
  output state_t            dbg_state
);

  // Counter must be able to reach TIMEOUT-1; at least one bit when disabled.
  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] wait_cnt;
  logic             accept;
  logic             timed_out;
  logic             done_ok;
  logic             done_to;

  assign accept    = cmd_valid && cmd_ready;
  assign dbg_state = state;

  // Next-state decode; pready takes priority over the timeout condition.
  always_comb begin
    state_next = state;
    timed_out  = 1'b0;
    done_ok    = 1'b0;
    done_to    = 1'b0;
    case (state)
      IDLE: begin
        if (accept) state_next = SETUP;
      end
      SETUP: begin
        state_next = ACCESS;
      end
      ACCESS: begin
        timed_out = (TIMEOUT != 0) && !pready && (wait_cnt == CNT_LAST);
        if (pready) begin
          done_ok    = 1'b1;
          state_next = IDLE;
        end else if (timed_out) begin
          done_to    = 1'b1;
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_next;
  end

  // Registered handshake and APB strobes, decoded from the next state so
  // they line up exactly with the state they describe.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cmd_ready <= 1'b0;
      psel      <= 1'b0;
      penable   <= 1'b0;
    end else begin
      cmd_ready <= (state_next == IDLE);
      psel      <= (state_next == SETUP) || (state_next == ACCESS);
      penable   <= (state_next == ACCESS);
    end
  end

  // Capture the command on acceptance; held stable for the whole transfer.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      paddr  <= '0;
      pwrite <= 1'b0;
      pwdata <= '0;
    end else if (accept) begin
      paddr  <= cmd_addr;
      pwrite <= cmd_write;
      pwdata <= cmd_wdata;
    end
  end

  // Wait-state counter: cleared while in SETUP (entry to ACCESS), counts
  // ACCESS cycles that see pready low.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wait_cnt <= '0;
    end else if (state == SETUP) begin
      wait_cnt <= '0;
    end else if ((state == ACCESS) && !pready) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

  // Response pulse and held response data. pslverr only matters with pready.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      rsp_valid <= done_ok || done_to;
      if (done_ok) begin
        rsp_rdata <= pwrite ? '0 : prdata;
        rsp_err   <= pslverr;
      end else if (done_to) begin
        rsp_rdata <= '0;
        rsp_err   <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_apb_master.sv
// Bench for apb_master: a small APB register-bank responder model with
// programmable wait states / error, a table of directed transfers, and
// hand-written sequences for back-to-back, timeout-disabled and reset cases.
module tb_apb_master;
  import apb_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT (TIMEOUT=16) ----------------
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [15:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic [15:0] paddr;
  logic        psel, penable, pwrite;
  logic [31:0] pwdata, prdata;
  logic        pready, pslverr;
  state_t      dbg_state;

  apb_master #(.ADDR_W(16), .DATA_W(32), .TIMEOUT(16)) dut (
    .clk(clk), .rstn(rstn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .paddr(paddr), .psel(psel), .penable(penable), .pwrite(pwrite),
    .pwdata(pwdata), .prdata(prdata), .pready(pready), .pslverr(pslverr),
    .dbg_state(dbg_state)
  );

  // ---------------- second DUT with timeout disabled ----------------
  logic        c0_valid, c0_ready, c0_write;
  logic [15:0] c0_addr;
  logic [31:0] c0_wdata;
  logic        r0_valid, r0_err;
  logic [31:0] r0_rdata;
  logic [15:0] p0_addr;
  logic        p0_sel, p0_enable, p0_write;
  logic [31:0] p0_wdata;
  state_t      dbg_state0;

  apb_master #(.ADDR_W(16), .DATA_W(32), .TIMEOUT(0)) dut0 (
    .clk(clk), .rstn(rstn),
    .cmd_valid(c0_valid), .cmd_ready(c0_ready), .cmd_write(c0_write),
    .cmd_addr(c0_addr), .cmd_wdata(c0_wdata),
    .rsp_valid(r0_valid), .rsp_rdata(r0_rdata), .rsp_err(r0_err),
    .paddr(p0_addr), .psel(p0_sel), .penable(p0_enable), .pwrite(p0_write),
    .pwdata(p0_wdata), .prdata(32'h0), .pready(1'b0), .pslverr(1'b0),
    .dbg_state(dbg_state0)
  );

  // ---------------- responder model ----------------
  int          rsp_waits  = 0;
  logic        rsp_never  = 1'b0;
  logic        rsp_slverr = 1'b0;
  int          wcnt;
  logic [31:0] regs [4];
  logic        mapped;

  assign mapped  = (paddr[15:4] == 12'h010) && (paddr[1:0] == 2'b00);
  assign pready  = psel && penable && !rsp_never && (wcnt >= rsp_waits);
  assign pslverr = pready && rsp_slverr;
  assign prdata  = mapped ? regs[paddr[3:2]] : APB_DEFAULT_RDATA;

  initial for (int i = 0; i < 4; i++) regs[i] = 32'h0;

  always @(posedge clk or negedge rstn) begin
    if (!rstn)                 wcnt <= 0;
    else if (!(psel && penable)) wcnt <= 0;
    else if (!pready)          wcnt <= wcnt + 1;
  end

  always @(posedge clk) begin
    if (psel && penable && pready && pwrite && !pslverr && mapped)
      regs[paddr[3:2]] <= pwdata;
  end

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  typedef struct {
    string       name;
    logic        write;
    logic [15:0] addr;
    logic [31:0] wdata;
    int          waits;
    logic        never;
    logic        slverr;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
  } vec_t;

  // ---------------- driver: one complete transfer with checks ----------------
  task automatic run_txn(input vec_t v);
    int   guard;
    int   lat;
    int   n_sel;
    int   n_en;
    logic stable;
    logic got;
    logic [31:0] held;
    guard = 0;
    while (!cmd_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    chk({v.name, " ready"}, {31'h0, cmd_ready}, 32'h1);
    rsp_waits  = v.waits;
    rsp_never  = v.never;
    rsp_slverr = v.slverr;
    cmd_valid  = 1'b1;
    cmd_write  = v.write;
    cmd_addr   = v.addr;
    cmd_wdata  = v.wdata;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    cmd_write = ~v.write;
    cmd_addr  = 16'($urandom);
    cmd_wdata = $urandom;
    n_sel = 0; n_en = 0; stable = 1'b1; got = 1'b0; lat = 0;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      lat = c;
      if (rsp_valid) begin
        got = 1'b1;
        break;
      end
      if (psel) n_sel++;
      if (penable) n_en++;
      if (psel && ((paddr !== v.addr) || (pwrite !== v.write))) stable = 1'b0;
      if (penable && v.write && (pwdata !== v.wdata)) stable = 1'b0;
    end
    chk({v.name, " rsp_seen"}, {31'h0, got}, 32'h1);
    chk({v.name, " latency"}, 32'(lat), 32'(v.exp_lat));
    chk({v.name, " psel_cycles"}, 32'(n_sel), 32'(v.exp_lat - 1));
    chk({v.name, " penable_cycles"}, 32'(n_en), 32'(v.exp_lat - 2));
    chk({v.name, " addr_stable"}, {31'h0, stable}, 32'h1);
    chk({v.name, " rdata"}, rsp_rdata, v.exp_rdata);
    chk({v.name, " err"}, {31'h0, rsp_err}, {31'h0, v.exp_err});
    chk({v.name, " psel_drop"}, {30'h0, psel, penable}, 32'h0);
    chk({v.name, " ready_on_rsp"}, {31'h0, cmd_ready}, 32'h1);
    held = rsp_rdata;
    rsp_never  = 1'b0;
    rsp_slverr = 1'b0;
    rsp_waits  = 0;
    @(negedge clk);
    chk({v.name, " pulse_1cyc"}, {31'h0, rsp_valid}, 32'h0);
    chk({v.name, " rdata_hold"}, rsp_rdata, held);
  endtask

  vec_t tbl[$];
  int   guard;
  logic saw_rsp;

  initial begin
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    c0_valid  = 1'b0; c0_write  = 1'b0; c0_addr  = '0; c0_wdata  = '0;

    // ---------------- reset state ----------------
    repeat (2) @(negedge clk);
    chk("rst cmd_ready", {31'h0, cmd_ready}, 32'h0);
    chk("rst strobes", {29'h0, psel, penable, pwrite}, 32'h0);
    chk("rst rsp", {30'h0, rsp_valid, rsp_err}, 32'h0);
    chk("rst rsp_rdata", rsp_rdata, 32'h0);
    chk("rst paddr", {16'h0, paddr}, 32'h0);
    chk("rst pwdata", pwdata, 32'h0);
    chk("rst state", {30'h0, dbg_state}, {30'h0, IDLE});
    rstn = 1'b1;
    @(negedge clk);
    chk("ready after release", {31'h0, cmd_ready}, 32'h1);

    // ---------------- TIMEOUT=0: waits indefinitely ----------------
    c0_valid = 1'b1; c0_write = 1'b0; c0_addr = 16'h0300;
    @(posedge clk);
    #1 c0_valid = 1'b0;
    saw_rsp = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (r0_valid) saw_rsp = 1'b1;
    end
    chk("notimeout no_rsp", {31'h0, saw_rsp}, 32'h0);
    chk("notimeout still_access", {30'h0, p0_sel, p0_enable}, 32'h3);
    chk("notimeout ready_low", {31'h0, c0_ready}, 32'h0);

    // ---------------- table of directed transfers ----------------
    //            name          wr  addr      wdata          waits never err  exp_rdata      e_err lat
    tbl.push_back('{"wr100",     1, 16'h0100, 32'h0000_0005, 0, 1'b0, 1'b0, 32'h0,          1'b0, 3});
    tbl.push_back('{"rd100",     0, 16'h0100, 32'h0,         0, 1'b0, 1'b0, 32'h0000_0005,  1'b0, 3});
    tbl.push_back('{"rd200",     0, 16'h0200, 32'h0,         0, 1'b0, 1'b0, 32'h1234_5678,  1'b0, 3});
    tbl.push_back('{"wr104w2",   1, 16'h0104, 32'hA5A5_0001, 2, 1'b0, 1'b0, 32'h0,          1'b0, 5});
    tbl.push_back('{"rd104w4",   0, 16'h0104, 32'h0,         4, 1'b0, 1'b0, 32'hA5A5_0001,  1'b0, 7});
    tbl.push_back('{"rd100err",  0, 16'h0100, 32'h0,         0, 1'b0, 1'b1, 32'h0000_0005,  1'b1, 3});
    tbl.push_back('{"rd10Cto",   0, 16'h010C, 32'h0,         0, 1'b1, 1'b0, 32'h0,          1'b1, 18});
    tbl.push_back('{"wr108to",   1, 16'h0108, 32'hFFFF_FFFF, 0, 1'b1, 1'b0, 32'h0,          1'b1, 18});
    tbl.push_back('{"rd108",     0, 16'h0108, 32'h0,         0, 1'b0, 1'b0, 32'h0,          1'b0, 3});
    tbl.push_back('{"rd100w15",  0, 16'h0100, 32'h0,        15, 1'b0, 1'b0, 32'h0000_0005,  1'b0, 18});
    foreach (tbl[i]) run_txn(tbl[i]);

    // ---------------- pslverr write, next command on the response cycle ----------------
    rsp_slverr = 1'b1;
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 16'h0108; cmd_wdata = 32'h0000_DEAD;
    @(posedge clk);
    #1;
    cmd_addr = 16'h010C; cmd_wdata = 32'h0000_0077;
    guard = 0;
    do begin
      @(negedge clk);
      guard++;
    end while (!rsp_valid && guard < 10);
    chk("b2b first_lat", 32'(guard), 32'd3);
    chk("b2b first_err", {31'h0, rsp_err}, 32'h1);
    chk("b2b first_rdata", rsp_rdata, 32'h0);
    chk("b2b ready_on_rsp", {31'h0, cmd_ready}, 32'h1);
    rsp_slverr = 1'b0;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    @(negedge clk);
    chk("b2b second_setup", {30'h0, psel, penable}, 32'h2);
    chk("b2b second_addr", {16'h0, paddr}, 32'h0000_010C);
    guard = 0;
    do begin
      @(negedge clk);
      guard++;
    end while (!rsp_valid && guard < 10);
    chk("b2b second_lat", 32'(guard), 32'd2);
    chk("b2b second_err", {31'h0, rsp_err}, 32'h0);
    @(negedge clk);
    run_txn('{"rd108chk", 0, 16'h0108, 32'h0, 0, 1'b0, 1'b0, 32'h0,         1'b0, 3});
    run_txn('{"rd10Cchk", 0, 16'h010C, 32'h0, 1, 1'b0, 1'b0, 32'h0000_0077, 1'b0, 4});

    // ---------------- reset during ACCESS ----------------
    rsp_never = 1'b1;
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 16'h0100; cmd_wdata = 32'h0000_0009;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("midrst in_access", {30'h0, psel, penable}, 32'h3);
    #1 rstn = 1'b0;
    #1;
    chk("midrst strobes_async", {30'h0, psel, penable}, 32'h0);
    chk("midrst ready_async", {31'h0, cmd_ready}, 32'h0);
    saw_rsp = 1'b0;
    @(negedge clk);
    if (rsp_valid) saw_rsp = 1'b1;
    rstn = 1'b1;
    rsp_never = 1'b0;
    @(negedge clk);
    if (rsp_valid) saw_rsp = 1'b1;
    chk("midrst no_rsp", {31'h0, saw_rsp}, 32'h0);
    chk("midrst ready_next_edge", {31'h0, cmd_ready}, 32'h1);
    run_txn('{"wr104post", 1, 16'h0104, 32'h0BAD_F00D, 0, 1'b0, 1'b0, 32'h0,          1'b0, 3});
    run_txn('{"rd104post", 0, 16'h0104, 32'h0,         0, 1'b0, 1'b0, 32'h0BAD_F00D,  1'b0, 3});
    run_txn('{"rd100post", 0, 16'h0100, 32'h0,         0, 1'b0, 1'b0, 32'h0000_0005,  1'b0, 3});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
